// File: rtl/stereo_sample_fifo.sv
// Stereo sample pair FIFO with fill threshold state machine and sticky error flags.
// Optional feature: define UNDERRUN_HOLD_EN to repeat the last popped pair while empty.
module stereo_sample_fifo #(
    parameter int FIFO_WIDTH    = 6,
    parameter int AUD_BIT_DEPTH = 24
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic [AUD_BIT_DEPTH-1:0] lsound_in,
    input  logic [AUD_BIT_DEPTH-1:0] rsound_in,
    input  logic                     sound_valid,
    input  logic                     l_read,
    input  logic                     r_read,
    input  logic [FIFO_WIDTH:0]      buffersize,
    input  logic                     clear_flags,
    output logic [AUD_BIT_DEPTH-1:0] lsound_fifo,
    output logic [AUD_BIT_DEPTH-1:0] rsound_fifo,
    output logic [FIFO_WIDTH:0]      fill_level,
    output logic                     empty,
    output logic                     full,
    output logic                     buf_ready,
    output logic                     overflow,
    output logic                     underflow
);

    localparam int DEPTH = 2 ** FIFO_WIDTH;
    localparam logic [FIFO_WIDTH:0] LEVEL_FULL = (FIFO_WIDTH + 1)'(DEPTH);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FILL  = 2'd1,
        READY = 2'd2
    } state_t;

    logic [2*AUD_BIT_DEPTH-1:0] mem [DEPTH];
    logic [FIFO_WIDTH-1:0]      wr_ptr_reg;
    logic [FIFO_WIDTH-1:0]      rd_ptr_reg;
    logic [FIFO_WIDTH:0]        fill_level_reg;
    logic                       overflow_reg;
    logic                       underflow_reg;
    logic                       buf_ready_reg;
    state_t                     state_reg;
    logic [2*AUD_BIT_DEPTH-1:0] head_pair;
    logic [2*AUD_BIT_DEPTH-1:0] empty_pair;

    logic empty_w;
    logic full_w;
    logic wr_en;
    logic pop_en;
    logic drop_w;
    logic under_w;

    // Left reads only latch the head in the mux; the buffer has nothing to do for them.
    logic unused_l_read;
    assign unused_l_read = l_read;

    assign empty_w = (fill_level_reg == '0);
    assign full_w  = (fill_level_reg == LEVEL_FULL);
    // A pop on a full buffer frees the slot being written, so the write still goes in.
    assign wr_en   = sound_valid && (!full_w || r_read);
    assign pop_en  = r_read && !empty_w;
    assign drop_w  = sound_valid && full_w && !r_read;
    assign under_w = r_read && empty_w;

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr_reg] <= {lsound_in, rsound_in};
        end
    end

    assign head_pair = mem[rd_ptr_reg];

`ifdef UNDERRUN_HOLD_EN
    logic [2*AUD_BIT_DEPTH-1:0] hold_reg;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            hold_reg <= '0;
        end else if (pop_en) begin
            hold_reg <= head_pair;
        end
    end

    assign empty_pair = hold_reg;
`else
    assign empty_pair = '0;
`endif

    assign {lsound_fifo, rsound_fifo} = empty_w ? empty_pair : head_pair;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_reg     <= '0;
            rd_ptr_reg     <= '0;
            fill_level_reg <= '0;
            overflow_reg   <= 1'b0;
            underflow_reg  <= 1'b0;
        end else begin
            if (wr_en) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (pop_en) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
            case ({wr_en, pop_en})
                2'b10:   fill_level_reg <= fill_level_reg + 1'b1;
                2'b01:   fill_level_reg <= fill_level_reg - 1'b1;
                default: fill_level_reg <= fill_level_reg;
            endcase
            // Setting events take priority over a coincident clear.
            if (drop_w) begin
                overflow_reg <= 1'b1;
            end else if (clear_flags) begin
                overflow_reg <= 1'b0;
            end
            if (under_w) begin
                underflow_reg <= 1'b1;
            end else if (clear_flags) begin
                underflow_reg <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg     <= IDLE;
            buf_ready_reg <= 1'b0;
        end else if (buffersize == '0) begin
            state_reg     <= IDLE;
            buf_ready_reg <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (fill_level_reg != '0) begin
                        state_reg <= FILL;
                    end
                end
                FILL: begin
                    if (fill_level_reg >= buffersize) begin
                        state_reg     <= READY;
                        buf_ready_reg <= 1'b1;
                    end
                end
                READY: begin
                    if (fill_level_reg == '0) begin
                        state_reg     <= FILL;
                        buf_ready_reg <= 1'b0;
                    end
                end
                default: begin
                    state_reg     <= IDLE;
                    buf_ready_reg <= 1'b0;
                end
            endcase
        end
    end

    assign fill_level = fill_level_reg;
    assign empty      = empty_w;
    assign full       = full_w;
    assign buf_ready  = buf_ready_reg;
    assign overflow   = overflow_reg;
    assign underflow  = underflow_reg;

endmodule

// File: tb/tb_stereo_sample_fifo.sv
// Self-checking bench for stereo_sample_fifo: vector table plus scoreboard of written pairs.
// Follows the UNDERRUN_HOLD_EN define to pick the expected empty-buffer output.
module tb_stereo_sample_fifo;

    localparam int DEPTH = 64;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [23:0] lsound_in = '0;
    logic [23:0] rsound_in = '0;
    logic        sound_valid = 1'b0;
    logic        l_read = 1'b0;
    logic        r_read = 1'b0;
    logic [6:0]  buffersize = '0;
    logic        clear_flags = 1'b0;
    logic [23:0] lsound_fifo;
    logic [23:0] rsound_fifo;
    logic [6:0]  fill_level;
    logic        empty;
    logic        full;
    logic        buf_ready;
    logic        overflow;
    logic        underflow;

    stereo_sample_fifo #(.FIFO_WIDTH(6), .AUD_BIT_DEPTH(24)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .lsound_in  (lsound_in),
        .rsound_in  (rsound_in),
        .sound_valid(sound_valid),
        .l_read     (l_read),
        .r_read     (r_read),
        .buffersize (buffersize),
        .clear_flags(clear_flags),
        .lsound_fifo(lsound_fifo),
        .rsound_fifo(rsound_fifo),
        .fill_level (fill_level),
        .empty      (empty),
        .full       (full),
        .buf_ready  (buf_ready),
        .overflow   (overflow),
        .underflow  (underflow)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        sv;
        logic        lr;
        logic        rr;
        logic [23:0] l;
        logic [23:0] r;
        logic [6:0]  exp_fill;
        logic        exp_empty;
    } vec_t;

    vec_t        vecs [9];
    logic [47:0] sb_q [$];
    logic [47:0] last_pop = '0;
    int          total = 0;
    int          bad = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // One bus cycle: compare the head against the scoreboard, update the model, clock, check level.
    task automatic cycle(input logic sv, input logic lr, input logic rr,
                         input logic [23:0] l, input logic [23:0] r, input logic clr);
        logic [47:0] exp_head;
        sound_valid = sv;
        l_read      = lr;
        r_read      = rr;
        lsound_in   = l;
        rsound_in   = r;
        clear_flags = clr;
        if (lr || rr) begin
`ifdef UNDERRUN_HOLD_EN
            exp_head = (sb_q.size() > 0) ? sb_q[0] : last_pop;
`else
            exp_head = (sb_q.size() > 0) ? sb_q[0] : 48'h0;
`endif
            check("head", {lsound_fifo, rsound_fifo}, exp_head);
        end
        if (rr && sb_q.size() > 0) begin
            last_pop = sb_q.pop_front();
        end
        if (sv && sb_q.size() < DEPTH) begin
            sb_q.push_back({l, r});
        end
        @(posedge clk);
        #1;
        sound_valid = 1'b0;
        l_read      = 1'b0;
        r_read      = 1'b0;
        clear_flags = 1'b0;
        $display("txn sv=%0b lr=%0b rr=%0b clr=%0b in=%h_%h level=%0d", sv, lr, rr, clr, l, r, fill_level);
        check("level", fill_level, sb_q.size());
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{1'b1, 1'b0, 1'b0, 24'h000001, 24'h100001, 7'd1, 1'b0};
        vecs[1] = '{1'b1, 1'b0, 1'b0, 24'h000002, 24'h100002, 7'd2, 1'b0};
        vecs[2] = '{1'b1, 1'b0, 1'b0, 24'h000003, 24'h100003, 7'd3, 1'b0};
        vecs[3] = '{1'b0, 1'b1, 1'b0, 24'h0,      24'h0,      7'd3, 1'b0};
        vecs[4] = '{1'b0, 1'b0, 1'b1, 24'h0,      24'h0,      7'd2, 1'b0};
        vecs[5] = '{1'b0, 1'b1, 1'b0, 24'h0,      24'h0,      7'd2, 1'b0};
        vecs[6] = '{1'b0, 1'b0, 1'b1, 24'h0,      24'h0,      7'd1, 1'b0};
        vecs[7] = '{1'b0, 1'b1, 1'b0, 24'h0,      24'h0,      7'd1, 1'b0};
        vecs[8] = '{1'b0, 1'b0, 1'b1, 24'h0,      24'h0,      7'd0, 1'b1};

        // Reset values
        #2;
        check("rst_fill", fill_level, 7'd0);
        check("rst_empty", empty, 1'b1);
        check("rst_full", full, 1'b0);
        check("rst_ready", buf_ready, 1'b0);
        check("rst_flags", {overflow, underflow}, 2'b00);
        check("rst_head", {lsound_fifo, rsound_fifo}, 48'h0);
        @(posedge clk);
        @(posedge clk);
        #1;
        reset_n = 1'b1;

        // Basic write/read table
        for (int i = 0; i < 9; i++) begin
            cycle(vecs[i].sv, vecs[i].lr, vecs[i].rr, vecs[i].l, vecs[i].r, 1'b0);
            check("tbl_fill", fill_level, vecs[i].exp_fill);
            check("tbl_empty", empty, vecs[i].exp_empty);
        end

        // Fill to 64, then a dropped 65th write
        for (int i = 0; i < DEPTH; i++) begin
            cycle(1'b1, 1'b0, 1'b0, 24'h200000 + 24'(i), 24'h300000 + 24'(i), 1'b0);
        end
        check("full_flag", full, 1'b1);
        check("full_ovf_clear", overflow, 1'b0);
        cycle(1'b1, 1'b0, 1'b0, 24'hDEAD01, 24'hDEAD02, 1'b0);
        check("ovf_set", overflow, 1'b1);
        check("ovf_fill", fill_level, 7'd64);
        check("ovf_head", {lsound_fifo, rsound_fifo}, {24'h200000, 24'h300000});
        cycle(1'b0, 1'b0, 1'b1, 24'h0, 24'h0, 1'b0);
        cycle(1'b0, 1'b0, 1'b0, 24'h0, 24'h0, 1'b1);
        check("ovf_cleared", overflow, 1'b0);
        cycle(1'b1, 1'b0, 1'b0, 24'h4000AA, 24'h5000AA, 1'b0);
        check("refill_full", full, 1'b1);

        // Simultaneous write and pop on a full buffer
        cycle(1'b1, 1'b0, 1'b1, 24'hABCDEF, 24'h123456, 1'b0);
        check("wp_fill", fill_level, 7'd64);
        check("wp_ovf", overflow, 1'b0);
        for (int i = 0; i < DEPTH; i++) begin
            cycle(1'b0, 1'b0, 1'b1, 24'h0, 24'h0, 1'b0);
        end
        check("wp_last_pop", last_pop, {24'hABCDEF, 24'h123456});
        check("wp_empty", empty, 1'b1);

        // Underflow, clear colliding with a new underflow, then clear
        cycle(1'b0, 1'b1, 1'b1, 24'h0, 24'h0, 1'b0);
        check("unf_set", underflow, 1'b1);
`ifdef UNDERRUN_HOLD_EN
        check("unf_head", {lsound_fifo, rsound_fifo}, {24'hABCDEF, 24'h123456});
`else
        check("unf_head", {lsound_fifo, rsound_fifo}, 48'h0);
`endif
        cycle(1'b0, 1'b0, 1'b1, 24'h0, 24'h0, 1'b1);
        check("unf_set_wins", underflow, 1'b1);
        cycle(1'b0, 1'b0, 0, 24'h0, 24'h0, 1'b1);
        check("unf_cleared", underflow, 1'b0);
        // Pointers untouched by underflow: next write is the head
        cycle(1'b1, 1'b0, 1'b0, 24'h777777, 24'h888888, 1'b0);
        cycle(1'b0, 1'b0, 1'b1, 24'h0, 24'h0, 1'b0);
        check("unf_ptr", last_pop, {24'h777777, 24'h888888});

        // Threshold state machine with buffersize = 4
        buffersize = 7'd4;
        for (int i = 0; i < 4; i++) begin
            cycle(1'b1, 1'b0, 1'b0, 24'h600000 + 24'(i), 24'h700000 + 24'(i), 1'b0);
            check("thr_not_ready", buf_ready, 1'b0);
        end
        cycle(1'b0, 1'b0, 1'b0, 24'h0, 24'h0, 1'b0);
        check("thr_ready", buf_ready, 1'b1);
        for (int i = 0; i < 4; i++) begin
            cycle(1'b0, 1'b0, 1'b1, 24'h0, 24'h0, 1'b0);
            check("thr_drain_ready", buf_ready, 1'b1);
        end
        cycle(1'b0, 1'b0, 1'b0, 24'h0, 24'h0, 1'b0);
        check("thr_back_fill", buf_ready, 1'b0);
        cycle(1'b1, 1'b0, 1'b0, 24'h610000, 24'h710000, 1'b0);
        cycle(1'b1, 1'b0, 1'b0, 24'h610001, 24'h710001, 1'b0);
        cycle(1'b0, 1'b0, 1'b0, 24'h0, 24'h0, 1'b0);
        check("thr_two_below", buf_ready, 1'b0);
        buffersize = 7'd2;
        cycle(1'b0, 1'b0, 1'b0, 24'h0, 24'h0, 1'b0);
        check("thr_lowered", buf_ready, 1'b1);
        buffersize = 7'd0;
        cycle(1'b0, 1'b0, 1'b0, 24'h0, 24'h0, 1'b0);
        check("thr_disabled", buf_ready, 1'b0);
        cycle(1'b0, 1'b0, 1'b1, 24'h0, 24'h0, 1'b0);
        cycle(1'b0, 1'b0, 1'b1, 24'h0, 24'h0, 1'b0);

        // Asynchronous reset mid-fill
        for (int i = 0; i < 10; i++) begin
            cycle(1'b1, 1'b0, 1'b0, 24'h800000 + 24'(i), 24'h900000 + 24'(i), 1'b0);
        end
        check("mid_fill", fill_level, 7'd10);
        #2;
        reset_n = 1'b0;
        #1;
        check("arst_fill", fill_level, 7'd0);
        check("arst_empty", empty, 1'b1);
        check("arst_head", {lsound_fifo, rsound_fifo}, 48'h0);
        check("arst_flags", {full, buf_ready, overflow, underflow}, 4'b0000);
        sb_q.delete();
        last_pop = '0;
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        cycle(1'b1, 1'b0, 1'b0, 24'hC0FFEE, 24'hBEEF00, 1'b0);
        cycle(1'b0, 1'b1, 1'b0, 24'h0, 24'h0, 1'b0);
        cycle(1'b0, 1'b0, 1'b1, 24'h0, 24'h0, 1'b0);
        check("arst_readback", last_pop, {24'hC0FFEE, 24'hBEEF00});

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
